// File: rtl/pll_lock_reset_ctrl.sv
// PLL reset sequencer on the free-running reference clock: holds the PLL in reset,
// waits for lock with timeout/retry, requires a stable lock window, then releases core reset.
module pll_lock_reset_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int STABLE_CYCLES  = 4096,
    parameter int MAX_RETRIES    = 4,
    parameter int CNT_W          = 22
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAILED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       retries_r;
    logic [3:0]       retries_nxt_s;
    logic [3:0]       retries_inc_s;
    logic [7:0]       relock_r;
    logic [7:0]       relock_nxt_s;
    logic             meta_r;
    logic             lock_sync_r;
    logic             pll_rst_nxt_s;
    logic             core_reset_nxt_s;
    logic             ready_nxt_s;
    logic             fail_nxt_s;

    // Two-flop synchronizer bringing the asynchronous lock indication into refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            meta_r      <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            meta_r      <= pll_locked;
            lock_sync_r <= meta_r;
        end
    end

    // Sequencer state, shared counter, retry tally and relock tally
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r   <= ST_HOLD;
            cnt_r     <= CNT_ZERO;
            retries_r <= 4'd0;
            relock_r  <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            retries_r <= retries_nxt_s;
            relock_r  <= relock_nxt_s;
        end
    end

    // Next-state logic; the counter is cleared on every transition so it never wraps
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        retries_nxt_s = retries_r;
        relock_nxt_s  = relock_r;
        retries_inc_s = retries_r + 4'd1;
        case (state_r)
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT: begin
                // Lock takes priority over a timeout landing on the same cycle
                if (lock_sync_r) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    retries_nxt_s = retries_inc_s;
                    cnt_nxt_s     = CNT_ZERO;
                    if (retries_inc_s == RETRY_LIMIT) begin
                        state_nxt_s = ST_FAILED;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (!lock_sync_r) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s   = ST_RUN;
                    cnt_nxt_s     = CNT_ZERO;
                    retries_nxt_s = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_sync_r) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = CNT_ZERO;
                    if (relock_r != 8'd255) begin
                        relock_nxt_s = relock_r + 8'd1;
                    end else begin
                        relock_nxt_s = relock_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_FAILED: begin
                state_nxt_s = ST_FAILED;
            end
            default: begin
                state_nxt_s = ST_HOLD;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Moore output decode of the upcoming state so the registered outputs align with state
    always_comb begin
        pll_rst_nxt_s    = 1'b1;
        core_reset_nxt_s = 1'b1;
        ready_nxt_s      = 1'b0;
        fail_nxt_s       = 1'b0;
        case (state_nxt_s)
            ST_HOLD: begin
                pll_rst_nxt_s = 1'b1;
            end
            ST_WAIT, ST_SETTLE: begin
                pll_rst_nxt_s = 1'b0;
            end
            ST_RUN: begin
                pll_rst_nxt_s    = 1'b0;
                core_reset_nxt_s = 1'b0;
                ready_nxt_s      = 1'b1;
            end
            ST_FAILED: begin
                fail_nxt_s = 1'b1;
            end
            default: begin
                pll_rst_nxt_s = 1'b1;
            end
        endcase
    end

    // Registered control outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            pll_rst    <= pll_rst_nxt_s;
            core_reset <= core_reset_nxt_s;
            ready      <= ready_nxt_s;
            fail       <= fail_nxt_s;
        end
    end

    assign state        = state_r;
    assign relock_count = relock_r;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Vector-table bench for pll_lock_reset_ctrl: each record holds inputs for N edges,
// then the expected outputs, which travel through a scoreboard queue.
module tb_pll_lock_reset_ctrl;

    localparam logic [2:0] S_HOLD = 3'd0, S_WAIT = 3'd1, S_SETTLE = 3'd2,
                           S_RUN = 3'd3, S_FAILED = 3'd4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, core_reset, ready, fail;
    logic [7:0] relock_count;
    logic [2:0] state;

    typedef struct {
        string       tag;
        int          ncyc;
        logic        rst;
        logic        lock;
        logic [14:0] exp;
    } vec_t;

    vec_t        vq[$];
    logic [14:0] sb_q[$];
    int          tests = 0;
    int          failed = 0;

    pll_lock_reset_ctrl #(
        .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8),
        .MAX_RETRIES(3), .CNT_W(22)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .core_reset(core_reset), .ready(ready), .fail(fail),
        .relock_count(relock_count), .state(state)
    );

    always #5 refclk = ~refclk;

    function automatic void add(string tag, int n, logic r, logic lk, logic [2:0] st,
                                logic pr, logic cr, logic rdy, logic fl, logic [7:0] rc);
        vec_t v;
        v.tag = tag; v.ncyc = n; v.rst = r; v.lock = lk;
        v.exp = {st, pr, cr, rdy, fl, rc};
        vq.push_back(v);
    endfunction

    // Expected outputs per state (rst low)
    function automatic void add_st(string tag, int n, logic lk, logic [2:0] st, logic [7:0] rc);
        case (st)
            S_HOLD:   add(tag, n, 1'b0, lk, st, 1'b1, 1'b1, 1'b0, 1'b0, rc);
            S_WAIT,
            S_SETTLE: add(tag, n, 1'b0, lk, st, 1'b0, 1'b1, 1'b0, 1'b0, rc);
            S_RUN:    add(tag, n, 1'b0, lk, st, 1'b0, 1'b0, 1'b1, 1'b0, rc);
            default:  add(tag, n, 1'b0, lk, st, 1'b1, 1'b1, 1'b0, 1'b1, rc);
        endcase
    endfunction

    function automatic void add_rst(string tag, int n);
        add(tag, n, 1'b1, 1'b0, S_HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    endfunction

    // Lose lock from RUN and come back to the start of WAIT (lock kept low)
    function automatic void add_drop_to_wait(string tag, logic [7:0] rc_before, logic [7:0] rc_after);
        add_st({tag, "_run"}, 2, 1'b0, S_RUN, rc_before);
        add_st({tag, "_hold0"}, 1, 1'b0, S_HOLD, rc_after);
        add_st({tag, "_hold"}, 3, 1'b0, S_HOLD, rc_after);
        add_st({tag, "_wait0"}, 1, 1'b0, S_WAIT, rc_after);
    endfunction

    task automatic run_vecs();
        vec_t        v;
        logic [14:0] got;
        logic [14:0] want;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            rst = v.rst;
            pll_locked = v.lock;
            sb_q.push_back(v.exp);
            repeat (v.ncyc) @(posedge refclk);
            #1;
            got = {state, pll_rst, core_reset, ready, fail, relock_count};
            want = sb_q.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL %s: got st=%0d pll_rst=%b core_reset=%b ready=%b fail=%b relock=%0d, expected st=%0d pll_rst=%b core_reset=%b ready=%b fail=%b relock=%0d",
                         v.tag, got[14:12], got[11], got[10], got[9], got[8], got[7:0],
                         want[14:12], want[11], want[10], want[9], want[8], want[7:0]);
            end
        end
        vq.delete();
    endtask

    task automatic check_retries_zero(string tag);
        tests++;
        if (dut.retries_r !== 4'd0) begin
            failed++;
            $display("FAIL %s: retries=%0d, expected 0", tag, dut.retries_r);
        end
    endtask

    initial begin
        logic [7:0] rb, ra;
        @(posedge refclk);
        #1;

        // Reset and clean start: lock rises 10 cycles into WAIT
        add_rst("reset", 2);
        add_st("clean_hold", 3, 1'b0, S_HOLD, 8'd0);
        add_st("clean_wait0", 1, 1'b0, S_WAIT, 8'd0);
        add_st("clean_wait10", 10, 1'b0, S_WAIT, 8'd0);
        add_st("clean_sync", 2, 1'b1, S_WAIT, 8'd0);
        add_st("clean_settle0", 1, 1'b1, S_SETTLE, 8'd0);
        add_st("clean_settle7", 7, 1'b1, S_SETTLE, 8'd0);
        add_st("clean_run", 1, 1'b1, S_RUN, 8'd0);
        run_vecs();

        // 300 losses of lock; odd iterations re-lock during HOLD, which must be ignored
        for (int i = 0; i < 300; i++) begin
            rb = (i >= 255) ? 8'd255 : 8'(i);
            ra = (i >= 254) ? 8'd255 : 8'(i + 1);
            add_st("loss_run", 2, 1'b0, S_RUN, rb);
            add_st("loss_hold0", 1, 1'b0, S_HOLD, ra);
            if (i % 2 == 0) begin
                add_st("loss_hold", 3, 1'b0, S_HOLD, ra);
                add_st("loss_wait0", 1, 1'b0, S_WAIT, ra);
                add_st("loss_sync", 2, 1'b1, S_WAIT, ra);
            end else begin
                add_st("holdlock_hold", 3, 1'b1, S_HOLD, ra);
                add_st("holdlock_wait", 1, 1'b1, S_WAIT, ra);
            end
            add_st("loss_settle0", 1, 1'b1, S_SETTLE, ra);
            add_st("loss_settle7", 7, 1'b1, S_SETTLE, ra);
            add_st("loss_run_again", 1, 1'b1, S_RUN, ra);
        end
        run_vecs();

        // Short settle glitch: high 5, low 1, then high; full settle after the glitch
        add_drop_to_wait("glitch1", 8'd255, 8'd255);
        add_st("glitch1_sync", 2, 1'b1, S_WAIT, 8'd255);
        add_st("glitch1_settle", 3, 1'b1, S_SETTLE, 8'd255);
        add_st("glitch1_low", 1, 1'b0, S_SETTLE, 8'd255);
        add_st("glitch1_high", 1, 1'b1, S_SETTLE, 8'd255);
        add_st("glitch1_wait", 1, 1'b1, S_WAIT, 8'd255);
        add_st("glitch1_settle0", 1, 1'b1, S_SETTLE, 8'd255);
        add_st("glitch1_settle7", 7, 1'b1, S_SETTLE, 8'd255);
        add_st("glitch1_run", 1, 1'b1, S_RUN, 8'd255);
        run_vecs();
        check_retries_zero("glitch1_retries");

        // Glitch late in WAIT: the timeout window restarts, and lock seen on its last cycle wins
        add_drop_to_wait("glitch2", 8'd255, 8'd255);
        add_st("glitch2_wait20", 20, 1'b0, S_WAIT, 8'd255);
        add_st("glitch2_sync", 2, 1'b1, S_WAIT, 8'd255);
        add_st("glitch2_settle", 3, 1'b1, S_SETTLE, 8'd255);
        add_st("glitch2_settle_tail", 2, 1'b0, S_SETTLE, 8'd255);
        add_st("glitch2_rewait", 30, 1'b0, S_WAIT, 8'd255);
        add_st("glitch2_edge", 2, 1'b1, S_WAIT, 8'd255);
        add_st("glitch2_settle0", 1, 1'b1, S_SETTLE, 8'd255);
        add_st("glitch2_settle7", 7, 1'b1, S_SETTLE, 8'd255);
        add_st("glitch2_run", 1, 1'b1, S_RUN, 8'd255);
        run_vecs();
        check_retries_zero("glitch2_retries");

        // Reset in the middle of SETTLE clears the saturated relock count
        add_drop_to_wait("midsettle", 8'd255, 8'd255);
        add_st("midsettle_sync", 2, 1'b1, S_WAIT, 8'd255);
        add_st("midsettle_settle", 3, 1'b1, S_SETTLE, 8'd255);
        add_rst("midsettle_reset", 1);
        run_vecs();

        // Lock tied low: three HOLD+WAIT attempts, FAILED at edge 108, lock then ignored
        for (int a = 0; a < 3; a++) begin
            add_st("to_hold", 3, 1'b0, S_HOLD, 8'd0);
            add_st("to_wait0", 1, 1'b0, S_WAIT, 8'd0);
            add_st("to_wait31", 31, 1'b0, S_WAIT, 8'd0);
            if (a < 2) add_st("to_rehold", 1, 1'b0, S_HOLD, 8'd0);
            else       add_st("to_failed", 1, 1'b0, S_FAILED, 8'd0);
        end
        add_st("failed_lock_ignored", 20, 1'b1, S_FAILED, 8'd0);
        add_rst("failed_reset", 1);
        run_vecs();

        // Lock first seen on the WAIT counter==31 cycle of the first attempt
        add_st("simul_hold", 3, 1'b0, S_HOLD, 8'd0);
        add_st("simul_wait0", 1, 1'b0, S_WAIT, 8'd0);
        add_st("simul_wait29", 29, 1'b0, S_WAIT, 8'd0);
        add_st("simul_sync", 2, 1'b1, S_WAIT, 8'd0);
        add_st("simul_settle", 1, 1'b1, S_SETTLE, 8'd0);
        run_vecs();
        check_retries_zero("simul_retries");
        add_st("simul_settle7", 7, 1'b1, S_SETTLE, 8'd0);
        add_st("simul_run", 1, 1'b1, S_RUN, 8'd0);
        run_vecs();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
